// File: rtl/pim_pkg.sv
// Shared types and size helpers for the PIM window controllers.
// Window size, sum width and counter widths are derived from the kernel edge length.
package pim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic int unsigned calc_n(input int unsigned kernal);
      return kernal * kernal;
   endfunction

   function automatic int unsigned calc_ow(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // A single-position window still needs a one-bit counter.
   function automatic int unsigned calc_cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned calc_dw(input int unsigned sa_lat);
      return (sa_lat > 1) ? $clog2(sa_lat) : 1;
   endfunction

endpackage

// File: rtl/shift_adder_seq.sv
// Sequencer that streams a kernal*kernal window bit-serially into an external
// shift_adder and captures its ones-count once the adder latency has elapsed.
module shift_adder_seq
   import pim_pkg::*;
#(
   parameter  int unsigned kernal = 3,
   parameter  int unsigned SA_LAT = 1,
   localparam int unsigned N      = calc_n(kernal),
   localparam int unsigned OW     = calc_ow(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [N-1:0]  win,
   output logic          sa_rst,
   output logic          sa_in,
   input  logic [OW-1:0] sa_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [OW-1:0] res_data,
   output logic          busy
);

   localparam int unsigned CW = calc_cw(N);
   localparam int unsigned DW = calc_dw(SA_LAT);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [N-1:0]  r_shift;
   logic [CW-1:0] r_pos;
   logic [DW-1:0] r_drain;
   logic [OW-1:0] r_res_data;

   logic w_load;
   logic w_capture;
   logic w_start_ready;
   logic w_sa_rst;
   logic w_sa_in;
   logic w_pos_last;
   logic w_drain_last;

   assign w_pos_last   = (r_pos == CW'(N - 1));
   assign w_drain_last = (r_drain == DW'(SA_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, handshake strobes and adder controls.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_capture     = 1'b0;
      w_start_ready = 1'b0;
      w_sa_rst      = 1'b0;
      w_sa_in       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_start_ready = 1'b1;
            w_sa_rst      = 1'b1;
            if (start_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_sa_rst    = 1'b1;
            w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            w_sa_in = r_shift[0];
            if (w_pos_last) begin
               if (SA_LAT == 0) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_drain_last) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // Consumer handshake frees the block; a same-cycle start chains without a bubble.
            if (res_ready) begin
               w_start_ready = 1'b1;
               if (start_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_CLEAR;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Window shifter, position/drain counters and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift    <= '0;
         r_pos      <= '0;
         r_drain    <= '0;
         r_res_data <= '0;
      end else begin
         if (w_load)                      r_shift <= win;
         else if (r_state == ST_STREAM)   r_shift <= r_shift >> 1;

         if (r_state == ST_STREAM)        r_pos   <= w_pos_last ? '0 : r_pos + CW'(1);
         if (r_state == ST_DRAIN)         r_drain <= w_drain_last ? '0 : r_drain + DW'(1);
         if (w_capture)                   r_res_data <= sa_out;
      end
   end

   assign start_ready = w_start_ready;
   assign sa_rst      = w_sa_rst;
   assign sa_in       = w_sa_in;
   assign res_valid   = (r_state == ST_DONE);
   assign res_data    = r_res_data;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_adder_seq.sv
// Directed bench: two sequencer instances (3x3/SA_LAT=1 and 2x2/SA_LAT=0),
// each paired with a behavioural ones-count adder of matching latency.
module tb_shift_adder_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // default instance: kernal=3, SA_LAT=1
   logic       a_start_valid = 1'b0;
   logic       a_start_ready;
   logic [8:0] a_win = '0;
   logic       a_sa_rst, a_sa_in;
   logic [3:0] a_sa_out;
   logic       a_res_valid;
   logic       a_res_ready = 1'b0;
   logic [3:0] a_res_data;
   logic       a_busy;

   // small instance: kernal=2, SA_LAT=0
   logic       b_start_valid = 1'b0;
   logic       b_start_ready;
   logic [3:0] b_win = '0;
   logic       b_sa_rst, b_sa_in;
   logic [2:0] b_sa_out;
   logic       b_res_valid;
   logic       b_res_ready = 1'b0;
   logic [2:0] b_res_data;
   logic       b_busy;

   shift_adder_seq u_dut_a (
      .clk(clk), .rst(rst),
      .start_valid(a_start_valid), .start_ready(a_start_ready), .win(a_win),
      .sa_rst(a_sa_rst), .sa_in(a_sa_in), .sa_out(a_sa_out),
      .res_valid(a_res_valid), .res_ready(a_res_ready), .res_data(a_res_data),
      .busy(a_busy)
   );

   shift_adder_seq #(.kernal(2), .SA_LAT(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .start_valid(b_start_valid), .start_ready(b_start_ready), .win(b_win),
      .sa_rst(b_sa_rst), .sa_in(b_sa_in), .sa_out(b_sa_out),
      .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
      .busy(b_busy)
   );

   // Ones-count adders: registered sum (latency 1) and combinational sum (latency 0).
   logic [3:0] a_acc = '0;
   logic [2:0] b_acc = '0;
   always @(posedge clk) a_acc <= a_sa_rst ? 4'd0 : a_acc + 4'(a_sa_in);
   always @(posedge clk) b_acc <= b_sa_rst ? 3'd0 : b_acc + 3'(b_sa_in);
   assign a_sa_out = a_acc;
   assign b_sa_out = b_acc + 3'(b_sa_in);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic a_start(input logic [8:0] w);
      a_win         = w;
      a_start_valid = 1'b1;
      @(negedge clk);
      a_start_valid = 1'b0;
   endtask

   // Counts edges after the handshake edge until res_valid, bounded.
   task automatic a_wait_done(input int exp_lat, input string tag);
      int lat = 0;
      while (!a_res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk(tag, 32'(lat), 32'(exp_lat));
   endtask

   task automatic a_release();
      a_res_ready = 1'b1;
      @(negedge clk);
      a_res_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst start_ready", 32'(a_start_ready), 32'd1);
      chk("rst sa_rst",      32'(a_sa_rst),      32'd1);
      chk("rst sa_in",       32'(a_sa_in),       32'd0);
      chk("rst res_valid",   32'(a_res_valid),   32'd0);
      chk("rst res_data",    32'(a_res_data),    32'd0);
      chk("rst busy",        32'(a_busy),        32'd0);
      chk("rst b busy",      32'(b_busy),        32'd0);
      chk("rst b ready",     32'(b_start_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("idle busy", 32'(a_busy), 32'd0);

      // Single MSB set: eight zeros then a one, sum 1 after 11 edges.
      a_start(9'h100);
      a_win = 9'h1FF;
      chk("clear sa_rst", 32'(a_sa_rst), 32'd1);
      chk("clear sa_in",  32'(a_sa_in),  32'd0);
      chk("clear busy",   32'(a_busy),   32'd1);
      chk("clear ready",  32'(a_start_ready), 32'd0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk($sformatf("stream sa_in k=%0d", k), 32'(a_sa_in), 32'(k == 8));
         chk($sformatf("stream sa_rst k=%0d", k), 32'(a_sa_rst), 32'd0);
      end
      @(negedge clk);
      chk("drain res_valid", 32'(a_res_valid), 32'd0);
      chk("drain sa_in",     32'(a_sa_in),     32'd0);
      @(negedge clk);
      chk("msb res_valid", 32'(a_res_valid), 32'd1);
      chk("msb res_data",  32'(a_res_data),  32'd1);
      a_release();
      chk("release busy",  32'(a_busy),      32'd0);
      chk("release valid", 32'(a_res_valid), 32'd0);

      // Back-to-back all-ones then all-zeros.
      a_start(9'h1FF);
      a_wait_done(11, "ones latency");
      chk("ones res_data", 32'(a_res_data), 32'd9);
      a_res_ready   = 1'b1;
      a_start_valid = 1'b1;
      a_win         = 9'h000;
      #1;
      chk("b2b start_ready", 32'(a_start_ready), 32'd1);
      @(negedge clk);
      a_res_ready   = 1'b0;
      a_start_valid = 1'b0;
      chk("b2b no idle busy", 32'(a_busy),      32'd1);
      chk("b2b clear sa_rst", 32'(a_sa_rst),    32'd1);
      chk("b2b res_valid",    32'(a_res_valid), 32'd0);
      a_wait_done(11, "zeros latency");
      chk("zeros res_data", 32'(a_res_data), 32'd0);
      a_release();

      // Result held under back-pressure; starts offered meanwhile are ignored.
      a_start(9'h0F3);
      a_wait_done(11, "hold latency");
      chk("hold res_data", 32'(a_res_data), 32'd6);
      for (int i = 0; i < 5; i++) begin
         a_start_valid = 1'b1;
         a_win         = 9'h1FF;
         #1;
         chk($sformatf("hold start_ready %0d", i), 32'(a_start_ready), 32'd0);
         @(negedge clk);
         chk($sformatf("hold valid %0d", i), 32'(a_res_valid), 32'd1);
         chk($sformatf("hold data %0d", i),  32'(a_res_data),  32'd6);
      end
      a_start_valid = 1'b0;
      a_release();
      chk("hold ignored start", 32'(a_busy), 32'd0);
      a_release();
      chk("idle res_ready busy", 32'(a_busy),     32'd0);
      chk("idle res_ready data", 32'(a_res_data), 32'd6);

      // Asynchronous reset in the middle of STREAM.
      a_start(9'h0F0);
      repeat (5) @(negedge clk);
      chk("mid busy", 32'(a_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("async start_ready", 32'(a_start_ready), 32'd1);
      chk("async sa_rst",      32'(a_sa_rst),      32'd1);
      chk("async sa_in",       32'(a_sa_in),       32'd0);
      chk("async res_valid",   32'(a_res_valid),   32'd0);
      chk("async res_data",    32'(a_res_data),    32'd0);
      chk("async busy",        32'(a_busy),        32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post rst idle", 32'(a_busy), 32'd0);
      a_start(9'h155);
      a_wait_done(11, "post rst latency");
      chk("post rst res_data", 32'(a_res_data), 32'd5);
      a_release();

      // 2x2 window without drain.
      begin
         int lat;
         logic [3:0] pat;
         b_win         = 4'b0110;
         b_start_valid = 1'b1;
         @(negedge clk);
         b_start_valid = 1'b0;
         chk("b clear sa_rst", 32'(b_sa_rst), 32'd1);
         pat = 4'b0110;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b sa_in k=%0d", k), 32'(b_sa_in), 32'(pat[k]));
         end
         @(negedge clk);
         chk("b res_valid", 32'(b_res_valid), 32'd1);
         chk("b res_data",  32'(b_res_data),  32'd2);
         b_res_ready = 1'b1;
         @(negedge clk);
         b_res_ready = 1'b0;
         chk("b release busy", 32'(b_busy), 32'd0);

         b_win         = 4'hF;
         b_start_valid = 1'b1;
         @(negedge clk);
         b_start_valid = 1'b0;
         lat = 0;
         while (!b_res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         chk("b full latency",  32'(lat),        32'd5);
         chk("b full res_data", 32'(b_res_data), 32'd4);
         b_res_ready = 1'b1;
         @(negedge clk);
         b_res_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shift_adder_seq.md
SHIFT_ADDER_SEQ -- requirements
Module: shift_adder_seq

Interface
REQ-001 Parameter kernal, default 3, kernel edge length; the window holds N = kernal*kernal bits.
REQ-002 Parameter SA_LAT, default 1, cycles from the last sa_in bit until sa_out holds the final sum.
REQ-003 Derived constant OW = $clog2(N+1), default 4, sum width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start_valid  input  1  a new window is offered.
REQ-007 start_ready  output  1  the block accepts a window this cycle.
REQ-008 win  input  N  window bits; bit 0 is streamed first.
REQ-009 sa_rst  output  1  clear to the shift_adder datapath.
REQ-010 sa_in  output  1  serial bit to the shift_adder.
REQ-011 sa_out  input  OW  shift_adder running sum.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  the consumer accepts the result.
REQ-014 res_data  output  OW  captured sum.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL use the states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-017 start_ready SHALL be 1 in IDLE, and 1 in DONE when res_ready=1; it SHALL be 0 otherwise.
REQ-018 On a start handshake the block SHALL register win into an internal shift register and go to CLEAR.
REQ-019 CLEAR SHALL last exactly 1 cycle with sa_rst=1 and sa_in=0, then go to STREAM.
REQ-020 STREAM SHALL last exactly N cycles, with sa_in equal to window bit k in the k-th STREAM cycle (k=0..N-1) and sa_rst=0.
REQ-021 DRAIN SHALL last SA_LAT cycles with sa_in=0; SA_LAT=0 SHALL skip DRAIN.
REQ-022 On leaving DRAIN, or STREAM when SA_LAT=0, res_data SHALL capture sa_out and the FSM SHALL go to DONE.
REQ-023 DONE SHALL hold res_valid=1 and a stable res_data until res_ready=1.
REQ-024 A res_ready handshake SHALL return the FSM to IDLE, or to CLEAR if start_valid=1 in the same cycle; in that case the new win is captured and there is no idle bubble.
REQ-025 In IDLE sa_rst SHALL be 1 and sa_in SHALL be 0.
REQ-026 start_valid outside the ready states SHALL be ignored, and win changes during a run SHALL not affect sa_in.
REQ-027 res_ready while res_valid=0 SHALL have no effect.
REQ-028 The position counter SHALL be $clog2(N) bits wide, SHALL wrap to 0 on STREAM exit and SHALL never exceed N-1.
REQ-029 Per-run latency from start handshake to res_valid SHALL be 1+N+SA_LAT cycles, which is 11 at the defaults.

Reset
REQ-030 While rst=1 the block SHALL be in IDLE with start_ready=1, sa_rst=1, sa_in=0, res_valid=0, res_data=0 and busy=0.
REQ-031 rst asserted mid-run SHALL abort the run immediately and asynchronously; no result is produced and the held window is discarded.
REQ-032 After rst deasserts, the first start SHALL behave identically to the first start after power-up.

Structure
REQ-033 The state encoding and the N, OW and counter-width calculations SHALL live in a shared package, pim_pkg.
REQ-034 The block SHALL be a pure controller with no internal instance; the shift_adder instance SHALL be connected by the parent.
REQ-035 The bench SHALL pair the block with the real shift_adder or with a ones-count model of latency SA_LAT.

Verification
REQ-036 win=9'b100000000 -> sa_in=0 for 8 STREAM cycles then 1; res_valid on cycle 11; res_data=1.
REQ-037 win=9'h1FF, then win=9'h000 offered back-to-back with res_ready=1 -> res_data 9 then 0, with no IDLE cycle between runs.
REQ-038 res_ready held 0 for 5 cycles in DONE -> res_valid and res_data stable; start_valid ignored throughout.
REQ-039 rst pulsed at STREAM cycle 4 -> outputs immediately at reset values; the next run with win=9'b101010101 gives res_data=5.
REQ-040 kernal=2 and SA_LAT=0 -> STREAM is 4 cycles; win=4'b0110 gives res_data=2 on cycle 5.
